// File: rtl/hrm_memory_unit_if.sv
// hrm_memory_unit_if: bundles the control-unit strobes and the datapath
// results of the HRM data-memory unit.
//   master : control side, drives addr_i/r_i and all strobes, observes results
//   slave  : the memory unit itself
// Signals:
//   addr_i    immediate address          r_i       write data from register R
//   src_a     AR source (0 imm, 1 m_o)   w_ar      load AR
//   inc_ar    AR+1 mod DEPTH             dec_ar    AR-1 mod DEPTH
//   w_m       write r_i to mem[AR]       clr_start start zero-fill
//   m_o       registered read data       ar_o      current AR
//   oob       AR >= DEPTH (combinational)
//   busy      zero-fill running          clr_done  one-cycle fill-complete pulse
//   fsm_state zero-fill FSM state, for observation only
interface hrm_memory_unit_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] r_i;
    logic              src_a;
    logic              w_ar;
    logic              inc_ar;
    logic              dec_ar;
    logic              w_m;
    logic              clr_start;
    logic [DATA_W-1:0] m_o;
    logic [ADDR_W-1:0] ar_o;
    logic              oob;
    logic              busy;
    logic              clr_done;
    logic [1:0]        fsm_state;

    modport master (
        output addr_i, r_i, src_a, w_ar, inc_ar, dec_ar, w_m, clr_start,
        input  m_o, ar_o, oob, busy, clr_done, fsm_state
    );

    modport slave (
        input  addr_i, r_i, src_a, w_ar, inc_ar, dec_ar, w_m, clr_start,
        output m_o, ar_o, oob, busy, clr_done, fsm_state
    );
endinterface

// File: rtl/hrm_memory_unit.sv
// hrm_memory_unit: address register (AR) in front of a synchronous RAM with
// direct/indirect AR loading, wrapping inc/dec, out-of-range detection and a
// hardware zero-fill sequencer.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (AR, m_o, FSM; RAM is not reset)
//   bus    hrm_memory_unit_if.slave, see the interface header
//
// Zero-fill handshake: a one-cycle clr_start seen while idle is accepted on
// that edge; busy is high from the next cycle for exactly DEPTH+1 cycles,
// clr_done pulses in the last of them, and every strobe (including a new
// clr_start) is ignored while busy is high.
module hrm_memory_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    hrm_memory_unit_if.slave   bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]  LAST_P  = IDX_W'(DEPTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] ar;
    logic [DATA_W-1:0] rd;
    logic [1:0]        state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] ind_addr;
    logic              oob_c;
    logic              idle;

    // Width-extended compare so DEPTH == 2**ADDR_W never flags.
    assign oob_c = ({1'b0, ar} >= DEPTH_X);
    assign idx   = ar[IDX_W-1:0];
    assign idle  = (state == S_IDLE);

    // Indirect source: low ADDR_W bits of m_o, zero-extended when narrower.
    generate
        if (DATA_W >= ADDR_W) begin : g_ind_trunc
            assign ind_addr = rd[ADDR_W-1:0];
        end else begin : g_ind_ext
            assign ind_addr = {{(ADDR_W-DATA_W){1'b0}}, rd};
        end
    endgenerate

    // RAM write port: the fill sequencer owns it while clearing; user
    // writes use AR before this edge's update and are dropped when oob.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[ptr] <= '0;
        end else if (idle && bus.w_m && !oob_c) begin
            mem[idx] <= bus.r_i;
        end
    end

    // Registered read; non-blocking update gives read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd <= '0;
        end else begin
            rd <= oob_c ? '0 : mem[idx];
        end
    end

    // AR and zero-fill FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar    <= '0;
            state <= S_IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.clr_start) begin
                        state <= S_CLEAR;
                        ptr   <= '0;
                    end
                    if (bus.w_ar) begin
                        ar <= bus.src_a ? ind_addr : bus.addr_i;
                    end else if (bus.inc_ar && !bus.dec_ar) begin
                        ar <= (oob_c || ar == LAST_A) ? '0 : ar + 1'b1;
                    end else if (bus.dec_ar && !bus.inc_ar) begin
                        ar <= (oob_c || ar == '0) ? LAST_A : ar - 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (ptr == LAST_P) begin
                        state <= S_DONE;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.m_o       = rd;
    assign bus.ar_o      = ar;
    assign bus.oob       = oob_c;
    assign bus.busy      = !idle;
    assign bus.clr_done  = (state == S_DONE);
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_hrm_memory_unit.sv
// tb_hrm_memory_unit: drives hrm_memory_unit (DEPTH=200) with directed and
// random strobe sequences and compares every cycle against a behavioural
// model built from address arithmetic and a word array.
module tb_hrm_memory_unit;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 200;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hrm_memory_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    hrm_memory_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    int               ar_m;
    logic [DATA_W-1:0] mo_m;
    bit               mo_known;
    logic [DATA_W-1:0] mem_m [DEPTH];
    bit               known_m [DEPTH];
    int               busy_left;
    int               fill_idx;

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0] exp_q [$];
    bit                expv_q [$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        bus.addr_i    = '0;
        bus.r_i       = '0;
        bus.src_a     = 1'b0;
        bus.w_ar      = 1'b0;
        bus.inc_ar    = 1'b0;
        bus.dec_ar    = 1'b0;
        bus.w_m       = 1'b0;
        bus.clr_start = 1'b0;
    endtask

    task automatic model_reset();
        ar_m      = 0;
        mo_m      = '0;
        mo_known  = 1'b1;
        busy_left = 0;
        fill_idx  = 0;
        exp_q.delete();
        expv_q.delete();
    endtask

    // One clock edge: advance the model with the current inputs, then compare.
    task automatic cycle();
        bit               oob_c;
        logic [DATA_W-1:0] mo_n;
        bit               kn_n;
        oob_c = (ar_m >= DEPTH);
        mo_n  = oob_c ? '0 : mem_m[ar_m];
        kn_n  = oob_c ? 1'b1 : known_m[ar_m];
        exp_q.push_back(mo_n);
        expv_q.push_back(kn_n);
        if (busy_left > 0) begin
            if (fill_idx < DEPTH) begin
                mem_m[fill_idx]   = '0;
                known_m[fill_idx] = 1'b1;
                fill_idx++;
            end
            busy_left--;
        end else begin
            if (bus.w_m && !oob_c) begin
                mem_m[ar_m]   = bus.r_i;
                known_m[ar_m] = 1'b1;
            end
            if (bus.clr_start) begin
                busy_left = DEPTH + 1;
                fill_idx  = 0;
            end
            if (bus.w_ar)
                ar_m = bus.src_a ? int'(mo_m) : int'(bus.addr_i);
            else if (bus.inc_ar && !bus.dec_ar)
                ar_m = oob_c ? 0 : (ar_m + 1) % DEPTH;
            else if (bus.dec_ar && !bus.inc_ar)
                ar_m = oob_c ? DEPTH - 1 : (ar_m + DEPTH - 1) % DEPTH;
        end
        mo_m     = mo_n;
        mo_known = kn_n;
        @(posedge clk);
        #1;
        check_val("ar_o", bus.ar_o, ar_m);
        check_val("oob", bus.oob, (ar_m >= DEPTH));
        check_val("busy", bus.busy, (busy_left > 0));
        check_val("clr_done", bus.clr_done, (busy_left == 1));
        begin
            logic [DATA_W-1:0] e;
            bit v;
            e = exp_q.pop_front();
            v = expv_q.pop_front();
            if (v) check_val("m_o", bus.m_o, e);
        end
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic async_reset();
        set_idle();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_ar_o", bus.ar_o, 0);
        check_val("rst_m_o", bus.m_o, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_clr_done", bus.clr_done, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_ar(input int a);
        set_idle();
        bus.w_ar   = 1'b1;
        bus.addr_i = ADDR_W'(a);
        cycle();
        set_idle();
    endtask

    task automatic write_at(input int a, input logic [DATA_W-1:0] d);
        load_ar(a);
        bus.w_m = 1'b1;
        bus.r_i = d;
        cycle();
        set_idle();
    endtask

    // Start a fill; optionally hammer strobes while busy; stop early if abort_at > 0.
    task automatic run_fill(input bit noisy, input int abort_at);
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        set_idle();
        bus.clr_start = 1'b1;
        cycle();
        if (bus.busy) busy_cnt++;
        for (int k = 1; k <= DEPTH + 1; k++) begin
            if (abort_at > 0 && k > abort_at) begin
                async_reset();
                return;
            end
            set_idle();
            if (noisy) begin
                bus.w_m       = 1'b1;
                bus.r_i       = DATA_W'($urandom);
                bus.w_ar      = 1'($urandom_range(0, 1));
                bus.addr_i    = ADDR_W'($urandom);
                bus.inc_ar    = 1'($urandom_range(0, 1));
                bus.dec_ar    = 1'($urandom_range(0, 1));
                bus.clr_start = 1'($urandom_range(0, 1));
            end
            cycle();
            if (bus.busy) busy_cnt++;
            if (bus.clr_done) done_cnt++;
        end
        set_idle();
        check_val("fill_busy_cycles", busy_cnt, DEPTH + 1);
        check_val("fill_done_pulses", done_cnt, 1);
    endtask

    task automatic fill_ff();
        load_ar(0);
        for (int a = 0; a < DEPTH; a++) begin
            bus.w_m    = 1'b1;
            bus.r_i    = 8'hFF;
            bus.inc_ar = 1'b1;
            cycle();
        end
        set_idle();
    endtask

    task automatic sweep(input int split, input logic [DATA_W-1:0] lo, input logic [DATA_W-1:0] hi);
        for (int a = 0; a < DEPTH; a++) begin
            load_ar(a);
            cycle();
            check_val("sweep", bus.m_o, (a < split) ? lo : hi);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        set_idle();
        model_reset();
        for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ar_o", bus.ar_o, 0);
        check_val("rst_m_o", bus.m_o, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_clr_done", bus.clr_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Initial noisy fill makes every word known.
        run_fill(1'b1, 0);
        sweep(DEPTH, 8'h00, 8'h00);

        // Direct write/read and read-before-write.
        write_at(5, 8'hA5);
        cycle();
        check_val("direct_rd", bus.m_o, 8'hA5);
        bus.w_m = 1'b1;
        bus.r_i = 8'h3C;
        cycle();
        set_idle();
        check_val("rbw_old", bus.m_o, 8'hA5);
        cycle();
        check_val("rbw_new", bus.m_o, 8'h3C);

        // Indirect load.
        write_at(8'h10, 8'h20);
        write_at(8'h20, 8'h77);
        load_ar(8'h10);
        cycle();
        bus.src_a = 1'b1;
        bus.w_ar  = 1'b1;
        cycle();
        set_idle();
        check_val("ind_ar", bus.ar_o, 8'h20);
        cycle();
        check_val("ind_m_o", bus.m_o, 8'h77);

        // Wrap-around and priority.
        load_ar(DEPTH - 1);
        bus.inc_ar = 1'b1;
        cycle();
        set_idle();
        check_val("wrap_inc", bus.ar_o, 0);
        bus.dec_ar = 1'b1;
        cycle();
        set_idle();
        check_val("wrap_dec", bus.ar_o, DEPTH - 1);
        bus.inc_ar = 1'b1;
        bus.dec_ar = 1'b1;
        cycle();
        set_idle();
        check_val("inc_dec_hold", bus.ar_o, DEPTH - 1);
        bus.w_ar   = 1'b1;
        bus.inc_ar = 1'b1;
        bus.addr_i = 8'd7;
        cycle();
        set_idle();
        check_val("war_over_inc", bus.ar_o, 7);

        // Out of range.
        load_ar(250);
        check_val("oob_flag", bus.oob, 1);
        bus.w_m = 1'b1;
        bus.r_i = 8'hFF;
        cycle();
        set_idle();
        check_val("oob_m_o", bus.m_o, 0);
        bus.inc_ar = 1'b1;
        cycle();
        set_idle();
        check_val("oob_inc", bus.ar_o, 0);
        load_ar(250);
        bus.dec_ar = 1'b1;
        cycle();
        set_idle();
        check_val("oob_dec", bus.ar_o, DEPTH - 1);

        // Full fill after 0xFF pattern, then aborted fill.
        fill_ff();
        run_fill(1'b1, 0);
        sweep(DEPTH, 8'h00, 8'h00);
        fill_ff();
        run_fill(1'b0, DEPTH / 2);
        sweep(DEPTH / 2, 8'h00, 8'hFF);

        // Random traffic against the model.
        for (int n = 0; n < 500; n++) begin
            set_idle();
            bus.addr_i    = ADDR_W'($urandom);
            bus.r_i       = DATA_W'($urandom);
            bus.src_a     = 1'($urandom_range(0, 1));
            bus.w_ar      = ($urandom_range(0, 3) == 0);
            bus.inc_ar    = 1'($urandom_range(0, 1));
            bus.dec_ar    = 1'($urandom_range(0, 1));
            bus.w_m       = 1'($urandom_range(0, 1));
            bus.clr_start = ($urandom_range(0, 199) == 0);
            cycle();
        end
        set_idle();
        repeat (DEPTH + 3) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
